cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from BLK-bit lookahead blocks, with the carry chain cut into NUM_STAGES register segments.
Adds a valid/ready handshake with backpressure, four arithmetic modes (wrap/saturating × add/sub), a signed-overflow flag and synchronous reset.
Sits in the MACC datapath as the accumulate adder feeding the accumulator register, and as a standalone add/sub unit for the CNN ALU.

---
 rtl/cla_addsub_pipe.sv | 164 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor with wrap/saturate modes
module cla_addsub_pipe #(
  parameter int N          = 16,
  parameter int BLK        = 4,
  parameter int NUM_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NB  = N / BLK;
  localparam int BPS = NB / NUM_STAGES;
  localparam int SW  = BPS * BLK;
  localparam int L   = NUM_STAGES - 1;

  logic         adv;
  logic         acc;
  logic [N-1:0] b_eff;
  logic         cin_eff;

  // Whole pipe moves together; it only freezes when a finished result is not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign acc      = in_valid && in_ready;

  // Subtraction is a + ~b + 1, so the carry-in is forced high in sub modes.
  assign b_eff   = op[0] ? ~b : b;
  assign cin_eff = op[0] | cin;

  // One segment: BPS lookahead blocks, block carries chained between blocks.
  function automatic logic [SW:0] seg_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                          input logic ci);
    logic [SW-1:0]  s;
    logic           bc;
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           gg;
    logic           pp;
    s  = '0;
    bc = ci;
    for (int k = 0; k < BPS; k++) begin
      g    = x[k*BLK +: BLK] & y[k*BLK +: BLK];
      p    = x[k*BLK +: BLK] ^ y[k*BLK +: BLK];
      c    = '0;
      c[0] = bc;
      // Every bit carry is a flat group-generate/propagate term of the block carry-in.
      for (int i = 0; i < BLK; i++) begin
        gg = g[i];
        pp = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          gg = gg | (pp & g[j]);
          pp = pp & p[j];
        end
        c[i+1] = gg | (pp & bc);
      end
      s[k*BLK +: BLK] = p ^ c[BLK-1:0];
      bc = c[BLK];
    end
    return {bc, s};
  endfunction

  function automatic logic [N-1:0] put_seg(input logic [N-1:0] r, input logic [SW-1:0] seg,
                                           input int idx);
    logic [N-1:0] o;
    o = r;
    o[idx*SW +: SW] = seg;
    return o;
  endfunction

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_seg
    logic [N-1:0] src_a;
    logic [N-1:0] src_b;
    logic [N-1:0] src_r;
    logic [1:0]   src_op;
    logic         src_c;
    logic         src_v;
    logic [SW:0]  res;
    logic [N-1:0] q_a;
    logic [N-1:0] q_b;
    logic [N-1:0] q_r;
    logic [1:0]   q_op;
    logic         q_c;
    logic         q_v;

    if (s == 0) begin : g_first
      assign src_a  = a;
      assign src_b  = b_eff;
      assign src_r  = '0;
      assign src_op = op;
      assign src_c  = cin_eff;
      assign src_v  = acc;
    end else begin : g_next
      assign src_a  = g_seg[s-1].q_a;
      assign src_b  = g_seg[s-1].q_b;
      assign src_r  = g_seg[s-1].q_r;
      assign src_op = g_seg[s-1].q_op;
      assign src_c  = g_seg[s-1].q_c;
      assign src_v  = g_seg[s-1].q_v;
    end

    assign res = seg_add(src_a[s*SW +: SW], src_b[s*SW +: SW], src_c);

    // Segment register: operands travel along, lower sum bits accumulate in q_r.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_v <= 1'b0;
      end else if (adv) begin
        q_v  <= src_v;
        q_a  <= src_a;
        q_b  <= src_b;
        q_op <= src_op;
        q_c  <= res[SW];
        q_r  <= put_seg(src_r, res[SW-1:0], s);
      end
    end
  end

  logic         fin_ovf;
  logic         fin_cout;
  logic [N-1:0] fin_sum;
  logic         a_msb;
  logic         unused_bits;

  assign a_msb       = g_seg[L].q_a[N-1];
  assign unused_bits = ^{g_seg[L].q_a[N-2:0], g_seg[L].q_b[N-2:0]};

  // Overflow is judged on the raw result; saturation clamps toward the sign of a.
  always_comb begin
    fin_ovf  = (a_msb == g_seg[L].q_b[N-1]) && (g_seg[L].q_r[N-1] != a_msb);
    fin_cout = g_seg[L].q_op[0] ? ~g_seg[L].q_c : g_seg[L].q_c;
    fin_sum  = g_seg[L].q_r;
    if (g_seg[L].q_op[1] && fin_ovf) begin
      fin_sum = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_seg[L].q_v;
      sum       <= fin_sum;
      cout      <= fin_cout;
      ovf       <= fin_ovf;
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - randomized self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;

  localparam int N  = 16;
  localparam int BLK = 4;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.N(N), .BLK(BLK), .NUM_STAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int emitted = 0;

  // Slot i holds the transaction i edges after its accept; slot NS is the output.
  logic         mv   [NS+1];
  logic [N+1:0] mres [NS+1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [N+1:0] ref_res(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                           input logic [1:0] rop, input logic rcin);
    longint sa, sb, fs, mx, mn;
    longint unsigned ua, ub;
    logic [N-1:0] r;
    logic c, ov;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ua = ra;
    ub = rb;
    mx = (longint'(1) << (N - 1)) - 1;
    mn = -(longint'(1) << (N - 1));
    if (!rop[0]) begin
      fs = sa + sb + longint'(rcin);
      c  = (((ua + ub + longint'(rcin)) >> N) & 1) != 0;
    end else begin
      fs = sa - sb;
      c  = ua < ub;
    end
    ov = (fs > mx) || (fs < mn);
    r  = fs[N-1:0];
    if (rop[1] && ov) begin
      if (fs > 0) r = mx[N-1:0];
      else r = mn[N-1:0];
    end
    return {ov, c, r};
  endfunction

  // One clock cycle: drive, check against the model, take the edge, advance the model.
  task automatic step(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic [1:0] iop, input logic icin, input logic ordy,
                      input logic [N+1:0] exp_res, output logic acc_o);
    logic exp_ir;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    cin       = icin;
    out_ready = ordy;
    #1;
    exp_ir = rst_n && (!mv[NS] || ordy);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, mv[NS]);
    if (mv[NS]) begin
      check("sum", sum, mres[NS][N-1:0]);
      check("cout", cout, mres[NS][N]);
      check("ovf", ovf, mres[NS][N+1]);
    end
    acc_o = iv && exp_ir;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i <= NS; i++) mv[i] = 1'b0;
      mres[NS] = '0;
    end else if (!mv[NS] || ordy) begin
      if (mv[NS] && ordy) emitted++;
      for (int i = NS; i > 0; i--) begin
        mv[i]   = mv[i-1];
        mres[i] = mres[i-1];
      end
      mv[0]   = acc_o;
      mres[0] = exp_res;
      if (acc_o) accepted++;
    end
    #1;
  endtask

  task automatic run_one(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [1:0] iop,
                         input logic icin, input logic [N+1:0] exp_res);
    logic acc;
    step(1'b1, ia, ib, iop, icin, 1'b1, exp_res, acc);
    for (int i = 0; i <= NS; i++) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, '0, acc);
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return {1'b0, {(N-1){1'b1}}};
      1: return {1'b1, {(N-1){1'b0}}};
      2: return '1;
      3: return '0;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic acc;
    logic have;
    logic [N-1:0] ta, tb;
    logic [1:0] top;
    logic tcin;
    int sent;

    for (int i = 0; i <= NS; i++) begin
      mv[i]   = 1'b0;
      mres[i] = '0;
    end
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; cin = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;

    // Directed vectors with hand-derived results {ovf, cout, sum}.
    run_one(16'h00FF, 16'h0001, 2'b00, 1'b0, {1'b0, 1'b0, 16'h0100});
    run_one(16'hFFFF, 16'h0001, 2'b00, 1'b0, {1'b0, 1'b1, 16'h0000});
    run_one(16'h0005, 16'h0007, 2'b01, 1'b0, {1'b0, 1'b1, 16'hFFFE});
    run_one(16'h0007, 16'h0005, 2'b01, 1'b1, {1'b0, 1'b0, 16'h0002});
    run_one(16'h7FFF, 16'h0001, 2'b10, 1'b0, {1'b1, 1'b0, 16'h7FFF});
    run_one(16'h8000, 16'h0001, 2'b11, 1'b0, {1'b1, 1'b0, 16'h8000});
    run_one(16'h7FFF, 16'h0001, 2'b00, 1'b0, {1'b1, 1'b0, 16'h8000});
    run_one(16'h1234, 16'h0FFF, 2'b00, 1'b1, {1'b0, 1'b0, 16'h2234});

    // Six back-to-back transactions with a three-cycle consumer stall mid-stream.
    sent = 0; have = 1'b0; ta = '0; tb = '0; top = 2'b00; tcin = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!have && sent < 6) begin
        ta = pick_operand(); tb = pick_operand();
        top = 2'($urandom); tcin = 1'($urandom);
        have = 1'b1;
      end
      step(have, ta, tb, top, tcin, !(cyc >= 3 && cyc < 6), ref_res(ta, tb, top, tcin), acc);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
    end
    check("bp_sent", sent, 6);
    check("bp_drained", emitted, accepted);

    // Reset with two transactions in flight: neither may ever be emitted.
    step(1'b1, 16'h1111, 16'h2222, 2'b00, 1'b0, 1'b1, ref_res(16'h1111, 16'h2222, 2'b00, 1'b0), acc);
    step(1'b1, 16'h3333, 16'h0001, 2'b01, 1'b0, 1'b1, ref_res(16'h3333, 16'h0001, 2'b01, 1'b0), acc);
    rst_n = 1'b0;
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, '0, acc);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, '0);
    rst_n = 1'b1;
    accepted = emitted;
    for (int i = 0; i < NS + 3; i++) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, '0, acc);

    // Random regression with random source and sink behaviour.
    have = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ta = pick_operand(); tb = pick_operand();
        top = 2'($urandom); tcin = 1'($urandom);
        have = 1'b1;
      end
      step(have, ta, tb, top, tcin, $urandom_range(0, 3) != 0, ref_res(ta, tb, top, tcin), acc);
      if (acc) have = 1'b0;
    end
    for (int i = 0; i < NS + 2; i++) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, '0, acc);
    check("rand_drained", emitted, accepted);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
